// File: rtl/fact_unit_if.sv
// Data-memory bus slice seen by the factorial accelerator.
interface fact_unit_if;
  logic        sel;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done;

  modport master (output sel, we, a, wd, input rd, done);
  modport slave  (input sel, we, a, wd, output rd, done);
endinterface

// File: rtl/fact_unit.sv
// Memory-mapped iterative factorial accelerator (N, GO, STATUS, RESULT).
// Optional FACT_ERR_EN: operands above 12 are rejected with err instead of wrapping.
module fact_unit (
  input  logic        clk,
  input  logic        rst,
  fact_unit_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
`ifdef FACT_ERR_EN
    , S_ERR = 2'd3
`endif
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  n, cnt;
  logic [31:0] prod;
  logic        done, err, busy;
  logic        wr_n, start;
  logic        load, step, fin;
  logic        unused_wd;

  assign wr_n      = bus.sel & bus.we & (bus.a == 2'd0);
  assign start     = bus.sel & bus.we & (bus.a == 2'd1) & bus.wd[0];
  assign busy      = (state == S_CALC);
  assign unused_wd = ^bus.wd[31:4];

`ifdef FACT_ERR_EN
  logic set_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
`ifdef FACT_ERR_EN
    set_err  = 1'b0;
`endif
    case (state)
      S_CALC: begin
        if (cnt <= 4'd1) begin
          state_nx = S_DONE;
          fin      = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      // IDLE, DONE and ERR all accept a new start; CALC ignores it.
      default: begin
        if (start) begin
`ifdef FACT_ERR_EN
          if (n > 4'd12) begin
            state_nx = S_ERR;
            set_err  = 1'b1;
          end else begin
            state_nx = S_CALC;
            load     = 1'b1;
          end
`else
          state_nx = S_CALC;
          load     = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n    <= '0;
      cnt  <= '0;
      prod <= '0;
      done <= 1'b0;
`ifdef FACT_ERR_EN
      err  <= 1'b0;
`endif
    end else begin
      // n may change mid-run; the live count lives in cnt.
      if (wr_n) n <= bus.wd[3:0];
      if (load) begin
        cnt  <= n;
        prod <= 32'd1;
        done <= 1'b0;
`ifdef FACT_ERR_EN
        err  <= 1'b0;
`endif
      end
      if (step) begin
        prod <= prod * {28'd0, cnt};
        cnt  <= cnt - 4'd1;
      end
      if (fin) done <= 1'b1;
`ifdef FACT_ERR_EN
      if (set_err) begin
        err  <= 1'b1;
        done <= 1'b1;
        prod <= '0;
      end
`endif
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (bus.a)
        2'd0:    bus.rd = {28'd0, n};
        2'd2:    bus.rd = {29'd0, err, busy, done};
        2'd3:    bus.rd = prod;
        default: bus.rd = '0;
      endcase
    end
  end

  assign bus.done = done;
endmodule

// File: tb/tb_fact_unit.sv
// Scoreboard bench for fact_unit: directed register-map scenarios plus randomized runs
// checked against a cycle-count based factorial model.
module tb_fact_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fact_unit_if bus ();
  fact_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef FACT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] val;
    logic        dn;
  } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  // Reference model: operand captured at start, cycle of first CALC edge.
  int m_n = 0, m_run_n = 0, m_start = 0;
  bit m_started = 1'b0, m_err = 1'b0;

  function automatic int k_of(input int n);
    return (n <= 1) ? 1 : n;
  endfunction

  function automatic int elapsed();
    return cyc - m_start;
  endfunction

  // Partial product after e edges of computation: n*(n-1)*... stopping at factor 2.
  function automatic logic [31:0] prod_after(input int n, input int e);
    logic [31:0] p = 32'd1;
    for (int i = 0; i < e && (n - i) > 1; i++) p = p * (n - i);
    return p;
  endfunction

  function automatic bit m_busy();
    return m_started && !m_err && elapsed() < k_of(m_run_n);
  endfunction

  function automatic logic m_done();
    return m_started && (m_err || elapsed() >= k_of(m_run_n));
  endfunction

  function automatic logic [31:0] m_prod();
    if (!m_started || m_err) return 32'd0;
    return prod_after(m_run_n, elapsed());
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_n;
      2'd2:    return {29'd0, m_err, m_busy(), m_done()};
      2'd3:    return m_prod();
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.sel && !bus.we) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read a=%0d rd=%h", bus.a, bus.rd);
      end else begin
        e = exp_q.pop_front();
        if (bus.rd === e.val && bus.done === e.dn) passed++;
        else $display("FAIL read a=%0d t=%0t rd=%h want=%h done=%b want=%b",
                      e.a, $time, bus.rd, e.val, bus.done, e.dn);
      end
    end else if (!bus.sel) begin
      total++;
      if (bus.rd === 32'd0) passed++;
      else $display("FAIL rd_unselected t=%0t rd=%h want=0", $time, bus.rd);
    end
  end

  task automatic bus_idle();
    bus.sel = 1'b0; bus.we = 1'b0; bus.a = 2'd0; bus.wd = 32'd0;
  endtask

  task automatic rd_push(input logic [1:0] a, input logic [31:0] val);
    bus.sel = 1'b1; bus.we = 1'b0; bus.a = a; bus.wd = 32'd0;
    exp_q.push_back('{a, val, m_done()});
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic rd_chk(input logic [1:0] a);
    rd_push(a, m_read(a));
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [31:0] val);
    rd_push(a, val);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    if (a == 2'd0) m_n = int'(wd[3:0]);
    if (a == 2'd1 && wd[0] && !m_busy()) begin
      m_run_n   = m_n;
      m_start   = cyc + 1;
      m_started = 1'b1;
      m_err     = ERR_EN && (m_n > 12);
    end
    bus.sel = 1'b1; bus.we = 1'b1; bus.a = a; bus.wd = wd;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_n = 0; m_started = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    bus_idle();
    do_reset();
    for (int a = 0; a < 4; a++) rd_const(2'(a), 32'd0);

    // N=5: busy for 5 reads, then done with 120
    wr(2'd0, 32'd5); wr(2'd1, 32'd1);
    repeat (5) rd_const(2'd2, 32'h2);
    rd_const(2'd2, 32'h1);
    rd_const(2'd3, 32'h00000078);

    wr(2'd0, 32'd12); wr(2'd1, 32'd1);
    repeat (12) rd_chk(2'd2);
    rd_const(2'd2, 32'h1);
    rd_const(2'd3, 32'h1C8CFC00);

    for (int n = 0; n < 2; n++) begin
      wr(2'd0, 32'(n)); wr(2'd1, 32'd1);
      rd_const(2'd2, 32'h2);
      rd_const(2'd2, 32'h1);
      rd_const(2'd3, 32'd1);
    end

    // N=6 with a stray GO and an N rewrite mid-run
    wr(2'd0, 32'd6); wr(2'd1, 32'd1);
    rd_chk(2'd3);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd3);
    repeat (3) rd_const(2'd2, 32'h2);
    rd_const(2'd2, 32'h1);
    rd_const(2'd3, 32'h000002D0);
    rd_const(2'd0, 32'd3);

    wr(2'd0, 32'd13); wr(2'd1, 32'd1);
`ifdef FACT_ERR_EN
    rd_const(2'd2, 32'h5);
    rd_const(2'd3, 32'd0);
`else
    repeat (13) rd_const(2'd2, 32'h2);
    rd_const(2'd2, 32'h1);
    rd_const(2'd3, 32'h7328CC00);
`endif

    // Reset in the middle of N=10
    wr(2'd0, 32'd10); wr(2'd1, 32'd1);
    rd_chk(2'd3); rd_chk(2'd3); rd_chk(2'd2);
    do_reset();
    for (int a = 0; a < 4; a++) rd_const(2'(a), 32'd0);
    wr(2'd0, 32'd4); wr(2'd1, 32'd1);
    repeat (4) rd_chk(2'd2);
    rd_const(2'd2, 32'h1);
    rd_const(2'd3, 32'h18);

    repeat (25) begin
      int n, k, r;
      n = $urandom_range(0, 15);
      wr(2'd0, {$urandom_range(0, 32'hFFFF), 12'h000, 4'(n)});
      wr(2'd1, 32'd1);
      k = k_of(n);
      for (int j = 0; j < k + 2; j++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      wr(2'd1, $urandom());
        else if (r == 1) wr(2'd0, $urandom());
        else             rd_chk(2'(r % 4));
      end
      rd_chk(2'd2); rd_chk(2'd3); rd_chk(2'd0);
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
